serial_adder: RTL and testbench

Bit-serial adder built around the team's 1-bit fulladder cell (port order c1, x, y, sout, cout) plus a carry flip-flop. It loads two WIDTH-bit operands on a start strobe and adds them LSB-first, one bit per clock. When all bits are done it presents the registered sum and carry-out with a one-cycle done pulse. It is the sequential consumer of the fulladder stage: area-cheap multi-bit addition for datapaths that can tolerate WIDTH-cycle latency.

---
 rtl/serial_adder.sv | 102 ++++++++++
 tb/tb_serial_adder.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder on a 1-bit fulladder cell; optional ovf port via SERIAL_ADD_OVF_EN
module fulladder (
    input  logic c1,
    input  logic x,
    input  logic y,
    output logic sout,
    output logic cout
);
    assign sout = x ^ y ^ c1;
    assign cout = (x & y) | (c1 & (x ^ y));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic             carry;
    logic [CW-1:0]    count;
    logic             fa_sout;
    logic             fa_cout;

    fulladder u_fa (
        .c1   (carry),
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .sout (fa_sout),
        .cout (fa_cout)
    );

    assign busy = (state == ADD);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            carry <= 1'b0;
            count <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        count <= '0;
                        state <= ADD;
                    end else begin
                        state <= IDLE;
                    end
                end
                ADD: begin
                    s_sr  <= {fa_sout, s_sr[WIDTH-1:1]};
                    a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
                    carry <= fa_cout;
                    count <= count + 1'b1;
                    // Publish only on the last bit so partial sums never reach the port.
                    if (count == LAST) begin
                        sum   <= {fa_sout, s_sr[WIDTH-1:1]};
                        cout  <= fa_cout;
`ifdef SERIAL_ADD_OVF_EN
                        ovf   <= carry ^ fa_cout;
`endif
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - randomized self-checking bench for serial_adder against an arithmetic reference
`timescale 1ns/1ps
module tb_serial_adder;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one add from start to done; chain leaves start asserted in the DONE cycle with na/nb.
    task automatic run_add(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tci,
                           input bit already_started, input bit mid_start,
                           input bit chain, input logic [W-1:0] na, input logic [W-1:0] nb);
        logic [W:0]   full;
        logic [W-1:0] old_sum;
        logic         old_cout;
        int           busy_cnt;
        int           done_at;
        int           i;
        full = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tci};
        if (!already_started) begin
            @(negedge clk);
            a = ta; b = tb; cin = tci; start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        old_sum  = sum;
        old_cout = cout;
        busy_cnt = 0;
        done_at  = -1;
        i        = 0;
        while (done_at < 0 && i < W + 4) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_at = i;
            end else begin
                check("sum_hold", {63'd0, sum == old_sum && cout == old_cout}, 64'd1);
                if (mid_start && i == 3) begin
                    start = 1'b1; a = 8'h11; b = 8'h22;
                end
                if (mid_start && i == 4) start = 1'b0;
                @(negedge clk);
                i++;
            end
        end
        check("latency", 64'(done_at), 64'(W));
        check("busy_cycles", 64'(busy_cnt), 64'(W));
        check("sum", 64'(sum), 64'(full[W-1:0]));
        check("cout", 64'(cout), 64'(full[W]));
`ifdef SERIAL_ADD_OVF_EN
        check("ovf", 64'(ovf), 64'((ta[W-1] == tb[W-1]) && (full[W-1] != ta[W-1])));
`endif
        if (chain) begin
            a = na; b = nb; cin = 1'b0; start = 1'b1;
        end else begin
            @(negedge clk);
            check("done_pulse", {62'd0, done, busy}, 64'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
`ifdef SERIAL_ADD_OVF_EN
        check("rst_ovf", 64'(ovf), 64'd0);
`endif
        start = 1'b0; rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_stays", {62'd0, busy, done}, 64'd0);

        run_add(8'h35, 8'h4A, 1'b0, 0, 0, 0, 0, 0);
        run_add(8'hFF, 8'h01, 1'b0, 0, 0, 0, 0, 0);
        run_add(8'hFF, 8'hFF, 1'b1, 0, 0, 0, 0, 0);
        run_add(8'h00, 8'h00, 1'b1, 0, 0, 0, 0, 0);
        run_add(8'h35, 8'h4A, 1'b0, 0, 1, 0, 0, 0);
        run_add(8'h05, 8'h06, 1'b0, 0, 0, 1, 8'h10, 8'h20);
        run_add(8'h10, 8'h20, 1'b0, 1, 0, 0, 0, 0);
        run_add(8'h7F, 8'h01, 1'b0, 0, 0, 0, 0, 0);
        run_add(8'h80, 8'h80, 1'b0, 0, 0, 0, 0, 0);
        run_add(8'h40, 8'h20, 1'b0, 0, 0, 0, 0, 0);

        // Abort mid-operation, then confirm no stray done and a clean restart.
        @(negedge clk);
        a = 8'h35; b = 8'h4A; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_sum", 64'(sum), 64'd0);
        check("abort_flags", {61'd0, busy, done, cout}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < W + 2; k++) begin
            @(negedge clk);
            check("abort_no_done", {62'd0, done, busy}, 64'd0);
        end
        run_add(8'h01, 8'h02, 1'b0, 0, 0, 0, 0, 0);

        for (int k = 0; k < 20; k++)
            run_add(W'($urandom), W'($urandom), 1'($urandom), 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
